f1_sweep_ctrl: RTL and testbench

- Sequencer that drives the f1 4-input combinational block exhaustively through all 2^N_IN input vectors.
- Waits a programmable settle time per vector, then samples op and assembles the captured truth table.
- Compares the captured table against an expected table and reports pass/fail, mismatch count and first failing index.
- Sits between a bench/top-level controller and the f1 instance; replaces free-running toggle stimulus with a handshaked, self-checking sweep.

---
 rtl/f1_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_f1_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_sweep_ctrl.sv
// rtl/f1_sweep_ctrl.sv - exhaustive input sweep of f1 with settle wait, truth-table capture and compare
module f1_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 op,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   tt,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail
);

  localparam int          W        = 2**N_IN;
  localparam logic [3:0]  SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [W-1:0]    tt_q, tt_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] ff_q, ff_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tt_d    = tt_q;
    cnt_d   = cnt_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          vec_d   = '0;
          scnt_d  = SETTLE_L;
          busy_d  = 1'b1;
          tt_d    = '0;
          cnt_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          state_d = (SETTLE == 0) ? SAMPLE : WAIT;
        end
      end
      WAIT: begin
        scnt_d = scnt_q - 4'd1;
        if (scnt_q <= 4'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[idx_q] = op;
        if (op != expected[idx_q]) begin
          cnt_d = cnt_q + (N_IN+1)'(1);
          if (cnt_q == '0) ff_d = idx_q;
        end
        if (idx_q == {N_IN{1'b1}}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
          vec_d   = '0;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          vec_d   = idx_q + N_IN'(1);
          scnt_d  = SETTLE_L;
          state_d = (SETTLE == 0) ? SAMPLE : WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort beats a coinciding final sample: partial results are frozen as they were
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      vec_d   = '0;
      pass_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = idx_q;
      tt_d    = tt_q;
      cnt_d   = cnt_q;
      ff_d    = ff_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      scnt_q  <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= '0;
      cnt_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      cnt_q   <= cnt_d;
      ff_q    <= ff_d;
    end
  end

  assign vec          = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign tt           = tt_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_f1_sweep_ctrl.sv
// tb/tb_f1_sweep_ctrl.sv - bench for f1_sweep_ctrl: SETTLE=2 xor unit and SETTLE=0 and unit
module tb_f1_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_s [2];
  logic        abort_s [2];
  logic        op_s    [2];
  logic [15:0] exp_s   [2];
  logic [3:0]  vec_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        pass_s  [2];
  logic [15:0] tt_s    [2];
  logic [4:0]  cnt_s   [2];
  logic [3:0]  ff_s    [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int e0     [2];

  f1_sweep_ctrl #(.N_IN(4), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .expected(exp_s[0]), .op(op_s[0]), .vec(vec_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .tt(tt_s[0]),
    .mismatch_cnt(cnt_s[0]), .first_fail(ff_s[0])
  );

  f1_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .expected(exp_s[1]), .op(op_s[1]), .vec(vec_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .tt(tt_s[1]),
    .mismatch_cnt(cnt_s[1]), .first_fail(ff_s[1])
  );

  // unit 0 sees a^b^c^d, unit 1 sees a&b&c&d
  assign op_s[0] = ^vec_s[0];
  assign op_s[1] = &vec_s[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic f1_ref(int u, int i);
    logic [3:0] v;
    v = i[3:0];
    return (u == 0) ? ^v : &v;
  endfunction

  typedef struct packed {
    bit          act;
    int          k;
    int          vec;
    bit          busy;
    bit          done;
    bit          pass;
    logic [15:0] tt;
    int          cnt;
    int          ff;
  } mdl_t;

  mdl_t mdl [2];

  // k counts edges since the accepted start; vector i is sampled when k reaches (i+1)*(SETTLE+1)
  function automatic mdl_t model_step(mdl_t s, int u, logic st, logic ab, logic [15:0] ex);
    mdl_t n;
    int   p;
    int   i;
    logic b;
    n = s;
    p = (u == 0) ? 3 : 1;
    n.done = 1'b0;
    if (s.act) begin
      if (ab) begin
        n.act = 1'b0; n.vec = 0; n.busy = 1'b0; n.pass = 1'b0;
      end else begin
        n.k = s.k + 1;
        if (n.k % p == 0) begin
          i = n.k / p - 1;
          b = f1_ref(u, i);
          n.tt[i] = b;
          if (b != ex[i]) begin
            if (n.cnt == 0) n.ff = i;
            n.cnt = n.cnt + 1;
          end
          if (i == 15) begin
            n.act = 1'b0; n.busy = 1'b0; n.done = 1'b1; n.vec = 0; n.pass = (n.cnt == 0);
          end else begin
            n.vec = i + 1;
          end
        end
      end
    end else if (st) begin
      n.act = 1'b1; n.k = 0; n.vec = 0; n.busy = 1'b1;
      n.tt = '0; n.cnt = 0; n.ff = 0; n.pass = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= '0;
      mdl[1] <= '0;
    end else begin
      mdl[0] <= model_step(mdl[0], 0, start_s[0], abort_s[0], exp_s[0]);
      mdl[1] <= model_step(mdl[1], 1, start_s[1], abort_s[1], exp_s[1]);
    end
  end

  task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
    n_chk = n_chk + 1;
    if (act_v !== exp_v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act_v, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_vec", u),  32'(vec_s[u]),  32'(mdl[u].vec));
      chk($sformatf("u%0d_busy", u), 32'(busy_s[u]), 32'(mdl[u].busy));
      chk($sformatf("u%0d_done", u), 32'(done_s[u]), 32'(mdl[u].done));
      chk($sformatf("u%0d_pass", u), 32'(pass_s[u]), 32'(mdl[u].pass));
      chk($sformatf("u%0d_tt", u),   32'(tt_s[u]),   32'(mdl[u].tt));
      chk($sformatf("u%0d_cnt", u),  32'(cnt_s[u]),  32'(mdl[u].cnt));
      chk($sformatf("u%0d_ff", u),   32'(ff_s[u]),   32'(mdl[u].ff));
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge E0
  task automatic do_start(int u);
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
    e0[u] = cyc;
  endtask

  task automatic wait_done(int u, int lat);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done_s[u]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk($sformatf("u%0d_done_timeout", u), 32'd0, 32'd1);
    else       chk($sformatf("u%0d_done_latency", u), 32'(cyc - e0[u]), 32'(lat));
  endtask

  task automatic chk_result(string tag, int u, logic [15:0] t, logic p, int c, int f);
    chk({tag, "_tt"},   32'(tt_s[u]),   32'(t));
    chk({tag, "_pass"}, 32'(pass_s[u]), 32'(p));
    chk({tag, "_cnt"},  32'(cnt_s[u]),  32'(c));
    chk({tag, "_ff"},   32'(ff_s[u]),   32'(f));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    abort_s[0] = 1'b0; abort_s[1] = 1'b0;
    exp_s[0] = 16'h6996;
    exp_s[1] = 16'h8000;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_s[0]), 32'd0);
    chk("reset_vec",  32'(vec_s[0]),  32'd0);
    chk("reset_tt",   32'(tt_s[0]),   32'd0);
    chk("reset_cnt",  32'(cnt_s[1]),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_start(0);
    chk("start_busy", 32'(busy_s[0]), 32'd1);
    wait_done(0, 48);
    chk_result("xor_6996", 0, 16'h6996, 1'b1, 0, 0);

    exp_s[0] = 16'h6997;
    @(negedge clk);
    do_start(0);
    wait_done(0, 48);
    chk_result("xor_6997", 0, 16'h6996, 1'b0, 1, 0);

    exp_s[0] = 16'h9669;
    @(negedge clk);
    do_start(0);
    wait_done(0, 48);
    chk_result("xor_9669", 0, 16'h6996, 1'b0, 16, 0);

    exp_s[0] = 16'h6990;
    @(negedge clk);
    do_start(0);
    wait_done(0, 48);
    chk_result("xor_6990", 0, 16'h6996, 1'b0, 2, 1);

    @(negedge clk);
    do_start(1);
    wait_done(1, 16);
    chk_result("and_8000", 1, 16'h8000, 1'b1, 0, 0);
    do_start(1);
    chk("restart_on_done_busy", 32'(busy_s[1]), 32'd1);
    wait_done(1, 16);
    chk_result("and_8000_again", 1, 16'h8000, 1'b1, 0, 0);

    exp_s[0] = 16'h6997;
    @(negedge clk);
    do_start(0);
    repeat (10) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (9) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_busy", 32'(busy_s[0]), 32'd0);
    chk("abort_vec",  32'(vec_s[0]),  32'd0);
    chk_result("abort", 0, 16'h0016, 1'b0, 1, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(done_s[0]), 32'd0);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    e0[0] = cyc;
    chk("start_abort_busy", 32'(busy_s[0]), 32'd1);
    chk("start_abort_vec",  32'(vec_s[0]),  32'd0);
    wait_done(0, 48);
    chk_result("after_abort", 0, 16'h6996, 1'b0, 1, 0);

    exp_s[0] = 16'h6996;
    @(negedge clk);
    do_start(0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_s[0]), 32'd0);
    chk("async_rst_vec",  32'(vec_s[0]),  32'd0);
    chk("async_rst_tt",   32'(tt_s[0]),   32'd0);
    chk("async_rst_cnt",  32'(cnt_s[0]),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(0);
    wait_done(0, 48);
    chk_result("after_reset", 0, 16'h6996, 1'b1, 0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
